branch_resolve_queue: RTL and testbench

- In-order buffer between fetch/predict and execute for conditional branches.
- Fetch allocates one entry per predicted conditional branch, holding the PC and the local, global and tournament predictions.
- The branch unit resolves entries out of order by tag.
- The queue drains resolved entries in program order and produces the resolved-branch update stream consumed by the tournament predictor (result_* signals), plus a mispredict pulse.

---
 rtl/branch_resolve_queue_if.sv | 46 ++++
 rtl/branch_resolve_queue.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Bundles the fetch-allocate, branch-resolve, flush and predictor-update
// signals of the branch resolve queue into one port.
`ifndef XLEN
`define XLEN 32
`endif

interface branch_resolve_queue_if #(
  parameter int BRQ_LEN = 3
);
  logic               alloc_valid;
  logic [`XLEN-1:0]   alloc_PC;
  logic               alloc_local_taken;
  logic               alloc_global_taken;
  logic               alloc_tournament_taken;
  logic               alloc_ready;
  logic [BRQ_LEN-1:0] alloc_tag;
  logic               resolve_valid;
  logic [BRQ_LEN-1:0] resolve_tag;
  logic               resolve_taken;
  logic               flush;
  logic               result_cond_branch;
  logic [`XLEN-1:0]   result_PC;
  logic               result_taken;
  logic               result_local_taken;
  logic               result_global_taken;
  logic               mispredict;
  logic [BRQ_LEN:0]   count;

  // Fetch / branch unit / predictor side.
  modport master (
    output alloc_valid, alloc_PC, alloc_local_taken, alloc_global_taken,
           alloc_tournament_taken, resolve_valid, resolve_tag, resolve_taken,
           flush,
    input  alloc_ready, alloc_tag, result_cond_branch, result_PC, result_taken,
           result_local_taken, result_global_taken, mispredict, count
  );

  // Queue side.
  modport slave (
    input  alloc_valid, alloc_PC, alloc_local_taken, alloc_global_taken,
           alloc_tournament_taken, resolve_valid, resolve_tag, resolve_taken,
           flush,
    output alloc_ready, alloc_tag, result_cond_branch, result_PC, result_taken,
           result_local_taken, result_global_taken, mispredict, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches. Entries are allocated at
// the tail, resolved out of order by tag, and drained from the head in program
// order to form the tournament-predictor update stream. A drained mispredict
// squashes every younger entry.
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_queue #(
  parameter int BRQ_SIZE = 8,
  parameter int BRQ_LEN  = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  branch_resolve_queue_if.slave  brq
);

  localparam logic [BRQ_LEN:0] FULL = (BRQ_LEN+1)'(BRQ_SIZE);

  typedef struct packed {
    logic             valid;
    logic             resolved;
    logic [`XLEN-1:0] pc;
    logic             ltaken;
    logic             gtaken;
    logic             ttaken;
    logic             actual;
  } entry_t;

  entry_t             entry_q [BRQ_SIZE];
  entry_t             entry_d [BRQ_SIZE];
  logic [BRQ_LEN-1:0] head_q, head_d;
  logic [BRQ_LEN-1:0] tail_q, tail_d;
  logic [BRQ_LEN:0]   count_q, count_d;

  logic               res_valid_q, res_valid_d;
  logic [`XLEN-1:0]   res_pc_q, res_pc_d;
  logic               res_taken_q, res_taken_d;
  logic               res_ltaken_q, res_ltaken_d;
  logic               res_gtaken_q, res_gtaken_d;
  logic               mispredict_q, mispredict_d;

  logic               alloc_ready;
  logic               alloc_fire;
  logic               drain_fire;
  logic               drain_mp;

  // Handshake and drain decisions taken from the current state.
  always_comb begin
    alloc_ready = reset && (count_q != FULL);
    alloc_fire  = brq.alloc_valid && alloc_ready;
    drain_fire  = entry_q[head_q].valid && entry_q[head_q].resolved;
    drain_mp    = drain_fire && (entry_q[head_q].ttaken != entry_q[head_q].actual);
  end

  // Next-state for entries, pointers, count and the registered update stream.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    entry_d      = entry_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    res_valid_d  = 1'b0;
    mispredict_d = 1'b0;
    res_pc_d     = res_pc_q;
    res_taken_d  = res_taken_q;
    res_ltaken_d = res_ltaken_q;
    res_gtaken_d = res_gtaken_q;

    if (brq.flush) begin
      for (int i = 0; i < BRQ_SIZE; i++) begin
        entry_d[i].valid    = 1'b0;
        entry_d[i].resolved = 1'b0;
      end
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (brq.resolve_valid && entry_q[brq.resolve_tag].valid &&
          !(alloc_fire && (brq.resolve_tag == tail_q))) begin
        entry_d[brq.resolve_tag].resolved = 1'b1;
        entry_d[brq.resolve_tag].actual   = brq.resolve_taken;
      end

      if (alloc_fire) begin
        entry_d[tail_q].valid    = 1'b1;
        entry_d[tail_q].resolved = 1'b0;
        entry_d[tail_q].pc       = brq.alloc_PC;
        entry_d[tail_q].ltaken   = brq.alloc_local_taken;
        entry_d[tail_q].gtaken   = brq.alloc_global_taken;
        entry_d[tail_q].ttaken   = brq.alloc_tournament_taken;
        entry_d[tail_q].actual   = 1'b0;
        tail_d = tail_q + BRQ_LEN'(1);
      end

      if (drain_fire) begin
        res_valid_d  = 1'b1;
        res_pc_d     = entry_q[head_q].pc;
        res_taken_d  = entry_q[head_q].actual;
        res_ltaken_d = entry_q[head_q].ltaken;
        res_gtaken_d = entry_q[head_q].gtaken;
        mispredict_d = drain_mp;
        entry_d[head_q].valid    = 1'b0;
        entry_d[head_q].resolved = 1'b0;
        head_d = head_q + BRQ_LEN'(1);
      end

      count_d = count_q + (BRQ_LEN+1)'(alloc_fire) - (BRQ_LEN+1)'(drain_fire);

      // Everything younger than a mispredicted branch is wrong-path work.
      if (drain_mp) begin
        for (int i = 0; i < BRQ_SIZE; i++) begin
          entry_d[i].valid    = 1'b0;
          entry_d[i].resolved = 1'b0;
        end
        tail_d  = head_q + BRQ_LEN'(1);
        count_d = '0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_pc_q     <= '0;
      res_taken_q  <= 1'b0;
      res_ltaken_q <= 1'b0;
      res_gtaken_q <= 1'b0;
      mispredict_q <= 1'b0;
      // NOTE: only valid/resolved are reset; payload fields are always
      // written by an allocation before anything can read them.
      for (int i = 0; i < BRQ_SIZE; i++) begin
        entry_q[i].valid    <= 1'b0;
        entry_q[i].resolved <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      entry_q      <= entry_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_pc_q     <= res_pc_d;
      res_taken_q  <= res_taken_d;
      res_ltaken_q <= res_ltaken_d;
      res_gtaken_q <= res_gtaken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign brq.alloc_ready         = alloc_ready;
  assign brq.alloc_tag           = tail_q;
  assign brq.count               = count_q;
  assign brq.result_cond_branch  = res_valid_q;
  assign brq.result_PC           = res_pc_q;
  assign brq.result_taken        = res_taken_q;
  assign brq.result_local_taken  = res_ltaken_q;
  assign brq.result_global_taken = res_gtaken_q;
  assign brq.mispredict          = mispredict_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: in-order drain, full/wrap,
// mispredict squash, flush, re-resolve and reset discard.
module tb_branch_resolve_queue;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  branch_resolve_queue_if #(.BRQ_LEN(3)) brq ();

  branch_resolve_queue #(.BRQ_SIZE(8), .BRQ_LEN(3)) dut (
    .clock (clock),
    .reset (reset),
    .brq   (brq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    brq.alloc_valid            = 1'b0;
    brq.alloc_PC               = '0;
    brq.alloc_local_taken      = 1'b0;
    brq.alloc_global_taken     = 1'b0;
    brq.alloc_tournament_taken = 1'b0;
    brq.resolve_valid          = 1'b0;
    brq.resolve_tag            = '0;
    brq.resolve_taken          = 1'b0;
    brq.flush                  = 1'b0;
  endtask

  task automatic drive_alloc(input logic [31:0] pc, input logic l, input logic g, input logic t);
    brq.alloc_valid            = 1'b1;
    brq.alloc_PC               = pc;
    brq.alloc_local_taken      = l;
    brq.alloc_global_taken     = g;
    brq.alloc_tournament_taken = t;
  endtask

  task automatic drive_resolve(input logic [2:0] tag, input logic taken);
    brq.resolve_valid = 1'b1;
    brq.resolve_tag   = tag;
    brq.resolve_taken = taken;
  endtask

  task automatic expect_pulse(input string tag, input logic [31:0] pc, input logic taken, input logic mp);
    check({tag, "_pulse"}, 32'(brq.result_cond_branch), 32'd1);
    check({tag, "_pc"}, brq.result_PC, pc);
    check({tag, "_taken"}, 32'(brq.result_taken), 32'(taken));
    check({tag, "_mp"}, 32'(brq.mispredict), 32'(mp));
  endtask

  function automatic logic [31:0] pc_of(input int t);
    return (t == 0) ? 32'h220 : 32'h200 + 32'(4 * t);
  endfunction

  initial begin
    idle();

    // Reset for two cycles, then release.
    reset = 1'b0;
    tick();
    check("rst_ready_low", 32'(brq.alloc_ready), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(brq.alloc_ready), 32'd1);
    check("rst_tag", 32'(brq.alloc_tag), 32'd0);
    check("rst_count", 32'(brq.count), 32'd0);
    check("rst_pulse", 32'(brq.result_cond_branch), 32'd0);
    check("rst_mp", 32'(brq.mispredict), 32'd0);

    // Three branches resolved out of order drain in program order.
    drive_alloc(32'h100, 1'b1, 1'b0, 1'b1); tick();
    drive_alloc(32'h104, 1'b0, 1'b1, 1'b1); tick();
    drive_alloc(32'h108, 1'b1, 1'b1, 1'b0); tick();
    idle();
    check("ooo_count", 32'(brq.count), 32'd3);
    check("ooo_tag", 32'(brq.alloc_tag), 32'd3);
    drive_resolve(3'd2, 1'b0); tick();
    check("ooo_nopulse_a", 32'(brq.result_cond_branch), 32'd0);
    drive_resolve(3'd0, 1'b1); tick();
    check("ooo_nopulse_b", 32'(brq.result_cond_branch), 32'd0);
    drive_resolve(3'd1, 1'b1); tick();
    expect_pulse("ooo0", 32'h100, 1'b1, 1'b0);
    check("ooo0_local", 32'(brq.result_local_taken), 32'd1);
    check("ooo0_global", 32'(brq.result_global_taken), 32'd0);
    idle(); tick();
    expect_pulse("ooo1", 32'h104, 1'b1, 1'b0);
    check("ooo1_local", 32'(brq.result_local_taken), 32'd0);
    check("ooo1_global", 32'(brq.result_global_taken), 32'd1);
    tick();
    expect_pulse("ooo2", 32'h108, 1'b0, 1'b0);
    tick();
    check("ooo_idle_pulse", 32'(brq.result_cond_branch), 32'd0);
    check("ooo_pc_hold", brq.result_PC, 32'h108);
    check("ooo_empty", 32'(brq.count), 32'd0);

    // Fill to capacity, overflow attempt, drain with wrap.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_alloc(32'h200 + 32'(4 * i), 1'b1, 1'b1, 1'b1);
      tick();
    end
    check("full_count", 32'(brq.count), 32'd8);
    check("full_ready", 32'(brq.alloc_ready), 32'd0);
    check("full_tag_wrap", 32'(brq.alloc_tag), 32'd0);
    drive_alloc(32'h300, 1'b1, 1'b1, 1'b1); tick();
    check("ninth_ignored", 32'(brq.count), 32'd8);
    drive_resolve(3'd0, 1'b1); tick();
    check("full_resolve_count", 32'(brq.count), 32'd8);
    brq.resolve_valid = 1'b0; tick();
    expect_pulse("full_drain", 32'h200, 1'b1, 1'b0);
    check("drain_count", 32'(brq.count), 32'd7);
    check("drain_ready", 32'(brq.alloc_ready), 32'd1);
    check("drain_tag", 32'(brq.alloc_tag), 32'd0);
    idle();
    drive_resolve(3'd1, 1'b1); tick();
    check("res1_nopulse", 32'(brq.result_cond_branch), 32'd0);
    idle();
    drive_alloc(32'h220, 1'b1, 1'b1, 1'b1); tick();
    expect_pulse("same_edge", 32'h204, 1'b1, 1'b0);
    check("same_edge_count", 32'(brq.count), 32'd7);
    check("same_edge_tag", 32'(brq.alloc_tag), 32'd1);
    idle();
    for (int k = 0; k < 7; k++) begin
      drive_resolve(3'((2 + k) % 8), 1'b1);
      tick();
      if (k > 0) expect_pulse($sformatf("wrap%0d", k), pc_of((1 + k) % 8), 1'b1, 1'b0);
      else check("wrap_first_nopulse", 32'(brq.result_cond_branch), 32'd0);
    end
    idle(); tick();
    expect_pulse("wrap_last", 32'h220, 1'b1, 1'b0);
    check("wrap_count", 32'(brq.count), 32'd0);
    check("wrap_tag", 32'(brq.alloc_tag), 32'd1);

    // Mispredict on tag 1 squashes tags 2 and 3 and a same-cycle allocation.
    reset = 1'b0; tick(); reset = 1'b1;
    drive_alloc(32'h400, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h404, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h408, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h40c, 1'b0, 1'b0, 1'b0); tick();
    idle();
    check("mp_count4", 32'(brq.count), 32'd4);
    drive_resolve(3'd0, 1'b1); tick();
    check("mp_nopulse", 32'(brq.result_cond_branch), 32'd0);
    drive_resolve(3'd1, 1'b0); tick();
    expect_pulse("mp_tag0", 32'h400, 1'b1, 1'b0);
    check("mp_count3", 32'(brq.count), 32'd3);
    drive_resolve(3'd2, 1'b1);
    drive_alloc(32'h500, 1'b1, 1'b1, 1'b1); tick();
    expect_pulse("mp_tag1", 32'h404, 1'b0, 1'b1);
    check("mp_squash_count", 32'(brq.count), 32'd0);
    check("mp_squash_tag", 32'(brq.alloc_tag), 32'd2);
    idle();
    drive_resolve(3'd3, 1'b1); tick();
    check("mp_tag2_none", 32'(brq.result_cond_branch), 32'd0);
    check("mp_tag2_mp", 32'(brq.mispredict), 32'd0);
    idle(); tick();
    check("mp_tag3_none", 32'(brq.result_cond_branch), 32'd0);
    check("mp_final_count", 32'(brq.count), 32'd0);
    check("mp_pc_hold", brq.result_PC, 32'h404);

    // Flush overrides a resolved-head drain and an allocation.
    drive_alloc(32'h600, 1'b1, 1'b1, 1'b1); tick();
    idle();
    drive_resolve(3'd2, 1'b1); tick();
    idle();
    brq.flush = 1'b1;
    drive_alloc(32'h604, 1'b1, 1'b1, 1'b1); tick();
    check("flush_pulse", 32'(brq.result_cond_branch), 32'd0);
    check("flush_mp", 32'(brq.mispredict), 32'd0);
    check("flush_count", 32'(brq.count), 32'd0);
    check("flush_tag", 32'(brq.alloc_tag), 32'd2);
    idle(); tick();
    check("flush_after_pulse", 32'(brq.result_cond_branch), 32'd0);
    check("flush_pc_hold", brq.result_PC, 32'h404);

    // Re-resolve before drain: last outcome wins.
    drive_alloc(32'h700, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h704, 1'b1, 1'b1, 1'b1); tick();
    idle();
    drive_resolve(3'd3, 1'b1); tick();
    drive_resolve(3'd3, 1'b0); tick();
    drive_resolve(3'd2, 1'b1); tick();
    check("rr_nopulse", 32'(brq.result_cond_branch), 32'd0);
    idle(); tick();
    expect_pulse("rr_tag2", 32'h700, 1'b1, 1'b0);
    tick();
    expect_pulse("rr_tag3", 32'h704, 1'b0, 1'b1);
    check("rr_count", 32'(brq.count), 32'd0);
    check("rr_tag", 32'(brq.alloc_tag), 32'd4);

    // Resolve of an empty slot, and resolve of the slot being allocated.
    drive_resolve(3'd4, 1'b1); tick();
    idle();
    drive_alloc(32'h800, 1'b1, 1'b1, 1'b1);
    drive_resolve(3'd4, 1'b1); tick();
    idle(); tick();
    check("alloc_res_a", 32'(brq.result_cond_branch), 32'd0);
    tick();
    check("alloc_res_b", 32'(brq.result_cond_branch), 32'd0);
    check("alloc_res_count", 32'(brq.count), 32'd1);

    // Reset with five pending entries, three of them resolved.
    drive_alloc(32'h900, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h904, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h908, 1'b1, 1'b1, 1'b1); tick();
    drive_alloc(32'h90c, 1'b1, 1'b1, 1'b1); tick();
    idle();
    check("pend_count", 32'(brq.count), 32'd5);
    for (int t = 5; t < 8; t++) begin
      drive_resolve(3'(t), 1'b1);
      tick();
      check($sformatf("pend_nopulse%0d", t), 32'(brq.result_cond_branch), 32'd0);
    end
    idle();
    reset = 1'b0;
    tick();
    check("rst2_pulse_a", 32'(brq.result_cond_branch), 32'd0);
    tick();
    check("rst2_pulse_b", 32'(brq.result_cond_branch), 32'd0);
    reset = 1'b1;
    #1;
    check("rst2_count", 32'(brq.count), 32'd0);
    check("rst2_tag", 32'(brq.alloc_tag), 32'd0);
    check("rst2_ready", 32'(brq.alloc_ready), 32'd1);
    check("rst2_pc", brq.result_PC, 32'h0);
    tick();
    check("rst2_after_a", 32'(brq.result_cond_branch), 32'd0);
    tick();
    check("rst2_after_b", 32'(brq.result_cond_branch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
